// File: rtl/prog_loader.sv
// Program loader and 16x8 instruction memory in front of the processor fetch path.
// Loads bytes over a synchronised strobe, holds the cpu in reset, then serves fetches.
module prog_loader #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  logic          wr_strobe,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] fetch_addr,
  output logic [DW-1:0] instruction,
  output logic          cpu_rst,
  output logic [AW:0]   load_cnt,
  output logic          prog_full,
  output logic          ovf
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_t        state;
  logic          s1, s2, s3;
  logic          pulse;
  logic          inc;
  logic          go_load;
  logic [AW:0]   cnt_inc;
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= wr_strobe;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign pulse       = s2 & ~s3;
  assign prog_full   = (load_cnt == FULL);
  assign inc         = pulse & ~prog_full;
  assign cnt_inc     = load_cnt + (AW+1)'(inc);
  assign go_load     = load_en && (state != LOAD);
  assign instruction = mem[fetch_addr];

  // Entering LOAD from IDLE or RUN wipes the program on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cpu_rst  <= 1'b1;
      load_cnt <= '0;
      ovf      <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (go_load) begin
      state    <= LOAD;
      cpu_rst  <= 1'b1;
      load_cnt <= '0;
      ovf      <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (inc)
            mem[load_cnt[AW-1:0]] <= wr_data;
          if (pulse && prog_full)
            ovf <= 1'b1;
          load_cnt <= cnt_inc;
          // Leave using the count that includes a coincident write.
          if (!load_en) begin
            if (cnt_inc != '0) begin
              state   <= RUN;
              cpu_rst <= 1'b0;
            end else begin
              state   <= IDLE;
              cpu_rst <= 1'b1;
            end
          end
        end
        RUN: begin
          state   <= RUN;
          cpu_rst <= 1'b0;
        end
        IDLE: begin
          state   <= IDLE;
          cpu_rst <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          cpu_rst <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: table vectors, a read scoreboard fed by a
// reference memory image, and hand-written multi-cycle sequences.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_en;
  logic       wr_strobe;
  logic [7:0] wr_data;
  logic [3:0] fetch_addr;
  logic [7:0] instruction;
  logic       cpu_rst;
  logic [4:0] load_cnt;
  logic       prog_full;
  logic       ovf;

  prog_loader #(.DEPTH(16), .AW(4), .DW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_en    (load_en),
    .wr_strobe  (wr_strobe),
    .wr_data    (wr_data),
    .fetch_addr (fetch_addr),
    .instruction(instruction),
    .cpu_rst    (cpu_rst),
    .load_cnt   (load_cnt),
    .prog_full  (prog_full),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] instr;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] mmem [16];
  int         mcnt;
  logic       movf;
  logic [7:0] sbq [$];

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mmem[i] = 8'h00;
    mcnt = 0;
    movf = 1'b0;
  endtask

  task automatic model_wr(input logic [7:0] d);
    if (mcnt < 16) begin
      mmem[mcnt] = d;
      mcnt++;
    end else begin
      movf = 1'b1;
    end
  endtask

  // one short strobe: high 1 cycle, low 3, data held throughout
  task automatic strobe(input logic [7:0] d, input bit in_load);
    wr_data   = d;
    wr_strobe = 1'b1;
    step(1);
    wr_strobe = 1'b0;
    step(3);
    if (in_load) model_wr(d);
  endtask

  task automatic rd(input string nm, input logic [3:0] a);
    fetch_addr = a;
    sbq.push_back(mmem[a]);
    #1;
    chk($sformatf("%s[%0d]", nm, a), instruction, sbq.pop_front());
    step(1);
  endtask

  task automatic rd_all(input string nm);
    for (int i = 0; i < 16; i++) rd(nm, 4'(i));
  endtask

  task automatic chk_stat(input string nm);
    chk({nm, ".load_cnt"}, load_cnt, mcnt);
    chk({nm, ".prog_full"}, prog_full, (mcnt == 16) ? 1 : 0);
    chk({nm, ".ovf"}, ovf, movf);
  endtask

  vec_t tbl [4];

  initial begin
    tbl[0] = '{4'd0, 8'h12};
    tbl[1] = '{4'd1, 8'h34};
    tbl[2] = '{4'd2, 8'h56};
    tbl[3] = '{4'd3, 8'h00};

    rst = 1'b1; load_en = 1'b0; wr_strobe = 1'b0;
    wr_data = 8'h00; fetch_addr = 4'd0;
    model_clear();
    step(2);
    rst = 1'b0;
    step(1);
    chk("reset.cpu_rst", cpu_rst, 1);
    chk_stat("reset");
    rd_all("reset.mem");

    // basic load/run
    load_en = 1'b1;
    step(1);
    chk("load.cpu_rst", cpu_rst, 1);
    strobe(8'h12, 1);
    strobe(8'h34, 1);
    strobe(8'h56, 1);
    load_en = 1'b0;
    step(1);
    chk("basic.cpu_rst", cpu_rst, 0);
    chk("basic.load_cnt", load_cnt, 3);
    for (int i = 0; i < 4; i++) begin
      fetch_addr = tbl[i].addr;
      sbq.push_back(tbl[i].instr);
      #1;
      chk($sformatf("basic.tbl[%0d]", i), instruction, sbq.pop_front());
      step(1);
    end

    // strobes in RUN are ignored
    strobe(8'hEE, 0);
    chk_stat("run_ign");
    rd("run_ign.mem", 4'd3);

    // full and overflow, entered from RUN
    load_en = 1'b1;
    step(1);
    model_clear();
    chk("reload.cpu_rst", cpu_rst, 1);
    chk_stat("reload");
    rd_all("reload.mem");
    for (int i = 0; i < 16; i++) strobe(8'hA0 + 8'(i), 1);
    chk_stat("full");
    strobe(8'hFF, 1);
    chk("ovf.ovf", ovf, 1);
    chk("ovf.full", prog_full, 1);
    chk_stat("ovf");
    load_en = 1'b0;
    step(1);
    chk("full.cpu_rst", cpu_rst, 0);
    rd_all("full.mem");

    // long strobe: one write only
    load_en = 1'b1;
    step(1);
    model_clear();
    wr_data = 8'h77;
    wr_strobe = 1'b1;
    step(10);
    wr_strobe = 1'b0;
    step(3);
    model_wr(8'h77);
    chk("long.load_cnt", load_cnt, 1);
    rd("long.mem", 4'd0);
    rd("long.mem", 4'd1);
    load_en = 1'b0;
    step(1);
    chk("long.cpu_rst", cpu_rst, 0);

    // empty load session returns to IDLE
    load_en = 1'b1;
    step(1);
    model_clear();
    load_en = 1'b0;
    step(1);
    chk("empty.cpu_rst", cpu_rst, 1);
    strobe(8'h99, 0);
    chk("empty.cpu_rst2", cpu_rst, 1);
    chk_stat("empty");

    // reset mid-load
    load_en = 1'b1;
    step(1);
    for (int i = 0; i < 5; i++) strobe(8'h30 + 8'(i), 1);
    chk("mid.load_cnt", load_cnt, 5);
    rst = 1'b1;
    load_en = 1'b0;
    #1;
    model_clear();
    chk("mid.async_cnt", load_cnt, 0);
    chk("mid.async_cpu", cpu_rst, 1);
    step(1);
    rst = 1'b0;
    step(2);
    chk("mid.cpu_rst", cpu_rst, 1);
    chk_stat("mid");
    for (int i = 0; i < 5; i++) rd("mid.mem", 4'(i));

    // strobe pulse coincident with load_en fall
    load_en = 1'b1;
    step(1);
    wr_data = 8'h5A;
    wr_strobe = 1'b1;
    step(1);
    wr_strobe = 1'b0;
    step(1);
    load_en = 1'b0;
    step(1);
    model_wr(8'h5A);
    chk("coin.cpu_rst", cpu_rst, 0);
    chk_stat("coin");
    rd("coin.mem", 4'd0);
    rd("coin.mem", 4'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Program loader and instruction memory placed directly upstream of the `processor` fetch path. While in load mode it accepts instruction bytes from the pad inputs over a strobe handshake and writes them into a 16 x 8 register memory. It holds the processor in reset during loading, then releases it. In run mode it returns the instruction addressed by the processor's 4-bit program counter.

## Interface

Parameters:
- `DEPTH`, 16: number of instruction words; must equal 2^`AW`.
- `AW`, 4: address width; matches the processor `addr_out`.
- `DW`, 8: instruction width.

Ports:
- `clk` in 1: single clock; all flops use the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `load_en` in 1: level; high requests load mode. Synchronous to `clk`.
- `wr_strobe` in 1: byte strobe from pads; asynchronous, 2-flop synchronised internally.
- `wr_data` in DW: byte to write.
- `fetch_addr` in AW: processor program counter (`addr_out`).
- `instruction` out DW: `mem[fetch_addr]`; combinational read.
- `cpu_rst` out 1: registered; high while not in RUN. Drives the processor reset.
- `load_cnt` out AW+1: bytes written since LOAD entry, 0..16.
- `prog_full` out 1: `load_cnt == DEPTH`.
- `ovf` out 1: sticky; a strobe arrived while full.

## Operation

- States are IDLE, LOAD and RUN. Reset enters IDLE.
- IDLE:
  - `load_en` high -> LOAD.
  - Otherwise stays in IDLE.
- LOAD:
  - On entry, clear all DEPTH memory words to 0x00, `load_cnt` to 0 and `ovf` to 0, all on the transition edge.
  - Each detected strobe pulse with `load_cnt < DEPTH`: `mem[load_cnt[AW-1:0]] <= wr_data` and `load_cnt++`.
  - Strobe pulse with `load_cnt == DEPTH`: no write; set `ovf`.
  - `load_en` low and `load_cnt > 0` -> RUN.
  - `load_en` low and `load_cnt == 0` -> IDLE.
- RUN:
  - `load_en` high -> LOAD, which clears memory and reasserts `cpu_rst`.
  - Memory is read-only in RUN; strobes are ignored and do not set `ovf`.
- Strobe detection:
  - Synchroniser chain is `s1`, `s2`, `s3`; pulse = `s2 & ~s3`.
  - Exactly one pulse per low-to-high transition of `wr_strobe`, regardless of how long it is held high.
- Write count never wraps: `load_cnt` saturates at DEPTH.
- `instruction` reads 0x00 for any address not written since the last LOAD entry.
- Simultaneous strobe pulse and `load_en` fall in the same cycle: the write is performed, then the state transition is taken using the incremented count.
- `rst` at any time, including mid-load, returns immediately to the reset values listed under Timing.

## Timing

- Reset values:
  - state IDLE
  - `cpu_rst` = 1
  - `load_cnt` = 0, `prog_full` = 0, `ovf` = 0
  - all mem = 0x00, so `instruction` = 0x00
  - synchroniser flops = 0
- Strobe latency:
  - `wr_strobe` rising before edge N is captured by `s1` at N, `s2` at N+1 and `s3` at N+2.
  - The write lands at edge N+2.
  - `wr_data` must be stable from the `wr_strobe` rise through edge N+2.
- Minimum strobe spacing: `wr_strobe` low for at least 2 cycles between bytes.
- `cpu_rst` is registered from the next state:
  - It deasserts on the same edge that enters RUN.
  - It asserts on the same edge that enters LOAD.
- `instruction` follows `fetch_addr` combinationally, with zero latency.
- `prog_full` is combinational from `load_cnt`.

## Test plan

- Reset: assert `rst` for 2 cycles, then release -> `cpu_rst` = 1, `load_cnt` = 0, `instruction` = 0x00 for all 16 addresses, `ovf` = 0.
- Basic load/run: `load_en` = 1; strobe 0x12, 0x34, 0x56; `load_en` = 0 -> `load_cnt` = 3 and `cpu_rst` falls. `fetch_addr` 0/1/2/3 -> `instruction` 0x12/0x34/0x56/0x00.
- Full and overflow: load 16 bytes 0xA0..0xAF, then a 17th strobe with 0xFF -> `prog_full` = 1, `ovf` = 1, `mem[0]` = 0xA0, `mem[15]` = 0xAF.
- Long strobe and empty load:
  - Hold `wr_strobe` high for 10 cycles -> exactly one write, `load_cnt` = 1.
  - A separate load session with no strobes: `load_en` pulse -> return to IDLE with `cpu_rst` still 1.
- Reload from RUN: in RUN with a program loaded, raise `load_en` -> `cpu_rst` = 1 on the next edge, all `instruction` reads 0x00, `load_cnt` = 0.
- Reset mid-load: after 5 bytes, pulse `rst` -> `load_cnt` = 0, memory cleared, state IDLE. The same edge case applies with a strobe pulse coincident with the `load_en` fall: the byte is written and the block enters RUN.
